// File: rtl/store_narrower_if.sv
`default_nettype none
// ============================================================================
// Module   : store_narrower_if
// Brief    : Request, status and data-memory signals of the store narrower.
// Revision : 1.0
// ============================================================================
interface store_narrower_if;
    logic        start;
    logic [1:0]  size;
    logic        Unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        misaligned;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    modport master (
        output start, size, Unsigned, addr, wdata, mem_rdata,
        input  busy, done, overflow, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  start, size, Unsigned, addr, wdata, mem_rdata,
        output busy, done, overflow, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/store_narrower.sv
`default_nettype none
// ============================================================================
// Module   : store_narrower
// Brief    : Narrows a register value to byte/halfword/word and merges it into
//            a word-wide big-endian memory by read-modify-write.
// Revision : 1.0
// ============================================================================
module store_narrower (
    input  logic                  clock,
    input  logic                  reset,
    store_narrower_if.slave       bus
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic [31:0] r_merged;
    logic        r_ovf;
    logic        r_mis;

    logic        w_accept;
    logic        w_mis;
    logic        w_ovf;
    logic [31:0] w_merge;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // Alignment and reserved-size check on the live request inputs
    always_comb begin
        w_mis = 1'b0;
        case (bus.size)
            c_SZ_BYTE: w_mis = 1'b0;
            c_SZ_HALF: w_mis = bus.addr[0];
            c_SZ_WORD: w_mis = (bus.addr[1:0] != 2'b00);
            default:   w_mis = 1'b1;
        endcase
    end

    // Truncation loss: the discarded upper bits must be a pure extension
    always_comb begin
        w_ovf = 1'b0;
        if (!w_mis) begin
            case (bus.size)
                c_SZ_BYTE: w_ovf = bus.Unsigned ? (|bus.wdata[31:8])
                                                : !((&bus.wdata[31:7]) || !(|bus.wdata[31:7]));
                c_SZ_HALF: w_ovf = bus.Unsigned ? (|bus.wdata[31:16])
                                                : !((&bus.wdata[31:15]) || !(|bus.wdata[31:15]));
                default:   w_ovf = 1'b0;
            endcase
        end
    end

    // Big-endian lane replacement over the word just read back
    always_comb begin
        w_merge = bus.mem_rdata;
        if (r_size == c_SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merge[31:24] = r_wdata[7:0];
                2'd1:    w_merge[23:16] = r_wdata[7:0];
                2'd2:    w_merge[15:8]  = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[15:0] = r_wdata;
        end else begin
            w_merge[31:16] = r_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_mis)                     w_next = ST_DONE;
                    else if (bus.size == c_SZ_WORD) w_next = ST_WRITE;
                    else                           w_next = ST_READ;
                end
            end
            ST_READ:  w_next = ST_MERGE;
            ST_MERGE: w_next = ST_WRITE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_size   <= 2'b00;
            r_addr   <= 32'd0;
            r_wdata  <= 16'd0;
            r_merged <= 32'd0;
            r_ovf    <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size   <= bus.size;
                r_addr   <= bus.addr;
                r_wdata  <= bus.wdata[15:0];
                // A word store writes the register value unchanged
                r_merged <= bus.wdata;
                r_ovf    <= w_ovf;
                r_mis    <= w_mis;
            end else if (r_state == ST_MERGE) begin
                r_merged <= w_merge;
            end
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.overflow   = (r_state == ST_DONE) && r_ovf;
    assign bus.misaligned = (r_state == ST_DONE) && r_mis;
    assign bus.mem_addr   = r_addr[31:2];
    assign bus.mem_rd     = (r_state == ST_READ);
    assign bus.mem_wr     = (r_state == ST_WRITE);
    assign bus.mem_wdata  = r_merged;

endmodule
`default_nettype wire

// File: tb/tb_store_narrower.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrower
// Brief    : Directed self-checking bench with a behavioural store model.
// Revision : 1.0
// ============================================================================
module tb_store_narrower;

    logic clock = 1'b0;
    logic reset;
    logic preload;

    always #5 clock = ~clock;

    store_narrower_if bus ();

    store_narrower dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Data memory: read data one cycle after mem_rd, write on mem_wr
    logic [31:0] mem [0:15];
    logic [31:0] last_wdata = 32'd0;
    int          cyc = 0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (preload) mem[4] = 32'h11223344;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
        if (bus.mem_wr) begin
            mem[bus.mem_addr[3:0]] = bus.mem_wdata;
            last_wdata = bus.mem_wdata;
        end
    end

    // Behavioural model: latency table per request class plus a shadow memory
    logic [31:0] shadow [0:15];
    int          k = 0;
    int          lat_done = 0;
    logic        m_err = 1'b0;
    logic        m_narrow = 1'b0;
    logic [3:0]  m_idx = 4'd0;
    logic [29:0] exp_maddr = 30'd0;
    logic [31:0] exp_word = 32'd0;
    logic        exp_ovf = 1'b0;

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [1:0] a, input logic [31:0] wd);
        logic [7:0] b [0:3];
        int lane;
        for (int i = 0; i < 4; i++) b[i] = old[31 - 8*i -: 8];
        lane = int'(a);
        if (sz == 2'b00) begin
            b[lane] = wd[7:0];
        end else if (sz == 2'b01) begin
            b[(lane / 2) * 2]     = wd[15:8];
            b[(lane / 2) * 2 + 1] = wd[7:0];
        end else begin
            return wd;
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic model_ovf(input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        longint s;
        longint u;
        s = longint'($signed(wd));
        u = {32'd0, wd};
        case (sz)
            2'b00:   return uns ? (u > 255)   : (s < -128 || s > 127);
            2'b01:   return uns ? (u > 65535) : (s < -32768 || s > 32767);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (preload) shadow[4] = 32'h11223344;
        if (reset) begin
            k = 0;
        end else if (k == 0) begin
            if (bus.start) begin
                m_err = (bus.size == 2'b11) || (bus.size == 2'b01 && bus.addr[0]) ||
                        (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
                m_narrow  = !m_err && (bus.size != 2'b10);
                lat_done  = m_err ? 1 : (bus.size == 2'b10 ? 2 : 4);
                m_idx     = bus.addr[5:2];
                exp_maddr = bus.addr[31:2];
                exp_word  = model_merge(shadow[bus.addr[5:2]], bus.size, bus.addr[1:0], bus.wdata);
                exp_ovf   = m_err ? 1'b0 : model_ovf(bus.size, bus.Unsigned, bus.wdata);
                k = 1;
            end
        end else if (k == lat_done) begin
            if (!m_err) shadow[m_idx] = exp_word;
            k = 0;
        end else begin
            k = k + 1;
        end
    end

    // Cycle-by-cycle comparison and event recording
    int   last_rd = -1;
    int   last_wr = -1;
    int   last_done = -1;
    int   done_total = 0;
    logic last_ovf = 1'b0;
    logic last_mis = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_ovf", bus.overflow, 0);
            chk("rst_mis", bus.misaligned, 0);
            chk("rst_rd", bus.mem_rd, 0);
            chk("rst_wr", bus.mem_wr, 0);
            chk("rst_maddr", 32'(bus.mem_addr), 0);
            chk("rst_mwdata", bus.mem_wdata, 0);
        end else begin
            chk("busy", bus.busy, 32'(k != 0));
            chk("done", bus.done, 32'(k != 0 && k == lat_done));
            chk("mem_rd", bus.mem_rd, 32'(k == 1 && m_narrow));
            chk("mem_wr", bus.mem_wr, 32'(k != 0 && !m_err && k == lat_done - 1));
            if (k != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
            if (k != 0 && !m_err && k == lat_done - 1) chk("mem_wdata", bus.mem_wdata, exp_word);
            if (k != 0 && k == lat_done) begin
                chk("overflow", bus.overflow, 32'(exp_ovf));
                chk("misaligned", bus.misaligned, 32'(m_err));
            end
            if (bus.mem_rd) last_rd = cyc;
            if (bus.mem_wr) last_wr = cyc;
            if (bus.done) begin
                last_done  = cyc;
                done_total = done_total + 1;
                last_ovf   = bus.overflow;
                last_mis   = bus.misaligned;
            end
        end
    end

    int start_cyc = 0;
    int done_before = 0;

    function automatic int rel(input int ev);
        return (ev >= start_cyc) ? (ev - start_cyc + 1) : 0;
    endfunction

    task automatic run(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input int pulse_at, input int rst_at);
        @(negedge clock);
        preload = 1'b1;
        @(posedge clock);
        #1 preload = 1'b0;
        @(negedge clock);
        done_before  = done_total;
        bus.size     = sz;
        bus.Unsigned = uns;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        start_cyc    = cyc;
        bus.start    = 1'b0;
        bus.size     = ~sz;
        bus.Unsigned = ~uns;
        bus.addr     = ~a;
        bus.wdata    = ~wd;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            bus.start = (c == pulse_at);
            if (c == rst_at) begin
                #2 reset = 1'b1;
                #1;
                chk("async_busy", bus.busy, 0);
                chk("async_wr", bus.mem_wr, 0);
                chk("async_rd", bus.mem_rd, 0);
                chk("async_done", bus.done, 0);
                @(posedge clock);
                #1 reset = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic expect_op(input string p, input int rd, input int wr, input int dn,
                             input logic [31:0] mem_exp, input logic ovf, input logic mis,
                             input logic [31:0] wexp);
        chk({p, "_rd_cycle"}, rel(last_rd), rd);
        chk({p, "_wr_cycle"}, rel(last_wr), wr);
        chk({p, "_done_cycle"}, rel(last_done), dn);
        chk({p, "_done_count"}, done_total - done_before, (dn != 0) ? 1 : 0);
        chk({p, "_mem"}, mem[4], mem_exp);
        chk({p, "_shadow"}, mem[4], shadow[4]);
        if (dn != 0) begin
            chk({p, "_ovf"}, last_ovf, ovf);
            chk({p, "_mis"}, last_mis, mis);
        end
        if (wr != 0) chk({p, "_wdata"}, last_wdata, wexp);
    endtask

    initial begin
        reset        = 1'b1;
        preload      = 1'b0;
        bus.start    = 1'b0;
        bus.size     = 2'b00;
        bus.Unsigned = 1'b0;
        bus.addr     = 32'd0;
        bus.wdata    = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        run(2'b00, 1'b0, 32'h11, 32'hFFFFFFC0, 0, 0);
        expect_op("byte_s", 1, 3, 4, 32'h11C03344, 1'b0, 1'b0, 32'h11C03344);
        run(2'b00, 1'b1, 32'h11, 32'hFFFFFFC0, 0, 0);
        expect_op("byte_u", 1, 3, 4, 32'h11C03344, 1'b1, 1'b0, 32'h11C03344);
        run(2'b00, 1'b0, 32'h10, 32'h0000007F, 0, 0);
        expect_op("byte_l0", 1, 3, 4, 32'h7F223344, 1'b0, 1'b0, 32'h7F223344);
        run(2'b00, 1'b0, 32'h13, 32'hFFFFFF7F, 0, 0);
        expect_op("byte_l3", 1, 3, 4, 32'h1122337F, 1'b1, 1'b0, 32'h1122337F);
        run(2'b01, 1'b0, 32'h12, 32'h000007C0, 0, 0);
        expect_op("half_s", 1, 3, 4, 32'h112207C0, 1'b0, 1'b0, 32'h112207C0);
        run(2'b01, 1'b0, 32'h12, 32'h00008000, 0, 0);
        expect_op("half_ovf", 1, 3, 4, 32'h11228000, 1'b1, 1'b0, 32'h11228000);
        run(2'b01, 1'b1, 32'h10, 32'h0001ABCD, 0, 0);
        expect_op("half_hi", 1, 3, 4, 32'hABCD3344, 1'b1, 1'b0, 32'hABCD3344);
        run(2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0);
        expect_op("word", 0, 1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF);
        run(2'b01, 1'b0, 32'h13, 32'h00001234, 0, 0);
        expect_op("err_half", 0, 0, 1, 32'h11223344, 1'b0, 1'b1, 32'h0);
        run(2'b11, 1'b0, 32'h10, 32'h00001234, 0, 0);
        expect_op("err_size", 0, 0, 1, 32'h11223344, 1'b0, 1'b1, 32'h0);
        run(2'b10, 1'b0, 32'h12, 32'h00001234, 0, 0);
        expect_op("err_word", 0, 0, 1, 32'h11223344, 1'b0, 1'b1, 32'h0);
        run(2'b00, 1'b0, 32'h11, 32'hFFFFFFC0, 2, 0);
        expect_op("busy_start", 1, 3, 4, 32'h11C03344, 1'b0, 1'b0, 32'h11C03344);
        run(2'b00, 1'b0, 32'h11, 32'hFFFFFFC0, 0, 2);
        expect_op("mid_reset", 1, 0, 0, 32'h11223344, 1'b0, 1'b0, 32'h0);
        run(2'b00, 1'b0, 32'h11, 32'hFFFFFFC0, 0, 0);
        expect_op("after_rst", 1, 3, 4, 32'h11C03344, 1'b0, 1'b0, 32'h11C03344);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
